// File: rtl/alu_cmd_issuer.sv
// Host-side command issuer for the 3-bit ALU: queues opcode/operand commands,
// drives them to the ALU for ALU_LAT cycles and returns each result over valid/ready.
module alu_cmd_issuer #(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_sel,
  input  logic [2:0] cmd_a,
  input  logic [2:0] cmd_b,
  output logic       alu_req,
  output logic [1:0] alu_sel,
  output logic [2:0] alu_a,
  output logic [2:0] alu_b,
  input  logic [5:0] alu_result,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [5:0] rsp_data,
  output logic [1:0] rsp_sel,
  output logic       busy,
  output logic [7:0] issued_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // state | meaning
  // IDLE  | nothing in flight, waiting for a queued command
  // DRIVE | operands held on the ALU port, counting down the ALU latency
  // RESP  | result captured, waiting for the host to take it
  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  state_t        state_q, state_d;
  logic [2:0]    lat_q, lat_d;
  logic          alu_req_q, alu_req_d;
  logic [1:0]    alu_sel_q, alu_sel_d;
  logic [2:0]    alu_a_q, alu_a_d;
  logic [2:0]    alu_b_q, alu_b_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [5:0]    rsp_data_q, rsp_data_d;
  logic [1:0]    rsp_sel_q, rsp_sel_d;
  logic [7:0]    issued_q, issued_d;
  logic          push;
  logic          pop;
  logic [7:0]    head;

  // Full is judged on the registered count only, so a same-cycle pop never reopens the FIFO.
  assign cmd_ready = ~rst & (count_q != CW'(DEPTH));
  assign push      = cmd_valid & cmd_ready;
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    alu_req_d   = alu_req_q;
    alu_sel_d   = alu_sel_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_sel_d   = rsp_sel_q;
    issued_d    = issued_q;
    pop         = 1'b0;

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop       = 1'b1;
          alu_sel_d = head[7:6];
          alu_a_d   = head[5:3];
          alu_b_d   = head[2:0];
          alu_req_d = 1'b1;
          lat_d     = 3'(ALU_LAT - 1);
          state_d   = DRIVE;
        end
      end
      DRIVE: begin
        if (lat_q != '0) begin
          lat_d = lat_q - 3'd1;
        end else begin
          rsp_data_d  = alu_result;
          rsp_sel_d   = alu_sel_q;
          rsp_valid_d = 1'b1;
          alu_req_d   = 1'b0;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_valid_q & rsp_ready) begin
          issued_d    = issued_q + 8'd1;
          rsp_valid_d = 1'b0;
          if (count_q != '0) begin
            pop       = 1'b1;
            alu_sel_d = head[7:6];
            alu_a_d   = head[5:3];
            alu_b_d   = head[2:0];
            alu_req_d = 1'b1;
            lat_d     = 3'(ALU_LAT - 1);
            state_d   = DRIVE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push & ~pop) count_d = count_q + CW'(1);
    else if (pop & ~push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      lat_q       <= '0;
      alu_req_q   <= 1'b0;
      alu_sel_q   <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_sel_q   <= '0;
      issued_q    <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      lat_q       <= lat_d;
      alu_req_q   <= alu_req_d;
      alu_sel_q   <= alu_sel_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_sel_q   <= rsp_sel_d;
      issued_q    <= issued_d;
    end
  end

  // Storage needs no reset: entries are only read once the count says they were written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_sel, cmd_a, cmd_b};
  end

  assign alu_req    = alu_req_q;
  assign alu_sel    = alu_sel_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_sel    = rsp_sel_q;
  assign issued_cnt = issued_q;
  assign busy       = (state_q != IDLE) | (count_q != '0);

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed and randomized bench for alu_cmd_issuer: ALU model, response scoreboard,
// a second instance built with ALU_LAT=3 for latency checks.
module tb_alu_cmd_issuer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_sel;
  logic [2:0] cmd_a, cmd_b;
  logic       alu_req;
  logic [1:0] alu_sel;
  logic [2:0] alu_a, alu_b;
  logic [5:0] alu_result;
  logic       rsp_valid, rsp_ready;
  logic [5:0] rsp_data;
  logic [1:0] rsp_sel;
  logic       busy;
  logic [7:0] issued_cnt;

  logic       cmd_valid3, cmd_ready3;
  logic [1:0] cmd_sel3;
  logic [2:0] cmd_a3, cmd_b3;
  logic       alu_req3;
  logic [1:0] alu_sel3;
  logic [2:0] alu_a3, alu_b3;
  logic [5:0] alu_result3;
  logic       rsp_valid3, rsp_ready3;
  logic [5:0] rsp_data3;
  logic [1:0] rsp_sel3;
  logic       busy3;
  logic [7:0] issued_cnt3;
  logic       corrupt3;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int cyc = 0;
  int prev_hs = -1;
  logic chk_spacing = 1'b0;
  logic rnd_en = 1'b0;
  logic hold_v = 1'b0;
  logic [5:0] hold_d;
  logic [1:0] hold_s;
  logic [7:0] mon_e;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [5:0] alu_model(input logic [1:0] s, input logic [2:0] a, input logic [2:0] b);
    logic [5:0] p;
    p = {3'b000, a} * {3'b000, b};
    return (s == 2'b10) ? p : {1'b0, a, s};
  endfunction

  assign alu_result  = alu_model(alu_sel, alu_a, alu_b);
  assign alu_result3 = corrupt3 ? ~alu_model(alu_sel3, alu_a3, alu_b3) : alu_model(alu_sel3, alu_a3, alu_b3);

  alu_cmd_issuer #(.DEPTH(4), .ALU_LAT(1)) u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_sel(cmd_sel), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_req(alu_req), .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_sel(rsp_sel), .busy(busy), .issued_cnt(issued_cnt)
  );

  alu_cmd_issuer #(.DEPTH(4), .ALU_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
    .cmd_sel(cmd_sel3), .cmd_a(cmd_a3), .cmd_b(cmd_b3),
    .alu_req(alu_req3), .alu_sel(alu_sel3), .alu_a(alu_a3), .alu_b(alu_b3),
    .alu_result(alu_result3), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
    .rsp_data(rsp_data3), .rsp_sel(rsp_sel3), .busy(busy3), .issued_cnt(issued_cnt3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [1:0] s, input logic [2:0] a, input logic [2:0] b);
    logic got;
    got = 1'b0;
    cmd_valid = 1'b1; cmd_sel = s; cmd_a = a; cmd_b = b;
    for (int i = 0; i < 5000 && !got; i++) begin
      @(negedge clk);
      if (cmd_ready) got = 1'b1;
    end
    if (got) exp_q.push_back({s, alu_model(s, a, b)});
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (!got) check("cmd_accept_timeout", got, 1);
  endtask

  task automatic wait_drain();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 20000 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy && !rsp_valid) done = 1'b1;
    end
    check("drain_timeout", done, 1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    hs_cnt = 0;
  endtask

  // Response monitor: hold-stability, scoreboard order, issue spacing.
  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("rsp_hold_valid", rsp_valid, 1);
        check("rsp_hold_data", rsp_data, hold_d);
        check("rsp_hold_sel", rsp_sel, hold_s);
      end
      if (rsp_valid && rsp_ready) begin
        check("rsp_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("rsp_data", rsp_data, mon_e[5:0]);
          check("rsp_sel", rsp_sel, mon_e[7:6]);
        end
        hs_cnt++;
        if (chk_spacing && prev_hs >= 0) check("rsp_spacing", cyc - prev_hs, 2);
        prev_hs = cyc;
      end
      hold_v = rsp_valid && !rsp_ready;
      hold_d = rsp_data;
      hold_s = rsp_sel;
    end
  end

  always @(posedge clk) begin
    if (rnd_en) begin
      #2;
      rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog_timeout cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_sel = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b1;
    cmd_valid3 = 1'b0; cmd_sel3 = '0; cmd_a3 = '0; cmd_b3 = '0; rsp_ready3 = 1'b1;
    corrupt3 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_alu_req", alu_req, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_issued", issued_cnt, 0);
    check("rst_cmd_ready3", cmd_ready3, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", cmd_ready, 1);
    check("post_rst_alu_fields", {alu_sel, alu_a, alu_b}, 0);
    check("post_rst_rsp_fields", {rsp_data, rsp_sel}, 0);

    // 1: single command latency
    @(posedge clk); #1;
    send(2'd2, 3'd5, 3'd7);
    @(negedge clk);
    check("t1_req_e0", alu_req, 0);
    check("t1_busy_e0", busy, 1);
    @(negedge clk);
    check("t1_req_e1", alu_req, 1);
    check("t1_alu_fields", {alu_sel, alu_a, alu_b}, {2'd2, 3'd5, 3'd7});
    check("t1_valid_e1", rsp_valid, 0);
    @(negedge clk);
    check("t1_req_e2", alu_req, 0);
    check("t1_valid_e2", rsp_valid, 1);
    check("t1_data", rsp_data, 35);
    check("t1_sel", rsp_sel, 2);
    @(negedge clk);
    check("t1_valid_e3", rsp_valid, 0);
    check("t1_issued", issued_cnt, 1);
    check("t1_busy_end", busy, 0);
    check("t1_alu_retain", {alu_sel, alu_a, alu_b}, {2'd2, 3'd5, 3'd7});

    // 3: ALU_LAT=3 instance, result sampled only on the third drive cycle
    @(posedge clk); #1;
    cmd_valid3 = 1'b1; cmd_sel3 = 2'd2; cmd_a3 = 3'd3; cmd_b3 = 3'd3; corrupt3 = 1'b1;
    @(negedge clk);
    check("t3_cmd_ready", cmd_ready3, 1);
    @(posedge clk); #1;
    cmd_valid3 = 1'b0;
    @(negedge clk);
    check("t3_req_e0", alu_req3, 0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("t3_req_drive", alu_req3, 1);
      check("t3_valid_drive", rsp_valid3, 0);
      check("t3_alu_fields", {alu_sel3, alu_a3, alu_b3}, {2'd2, 3'd3, 3'd3});
    end
    corrupt3 = 1'b0;
    @(negedge clk);
    check("t3_req_done", alu_req3, 0);
    check("t3_valid", rsp_valid3, 1);
    check("t3_data", rsp_data3, 9);
    check("t3_sel", rsp_sel3, 2);
    @(negedge clk);
    check("t3_valid_after", rsp_valid3, 0);
    check("t3_issued", issued_cnt3, 1);
    check("t3_busy_end", busy3, 0);

    // 2: fill under backpressure, stall, then drain back-to-back
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    send(2'd0, 3'd1, 3'd2);
    send(2'd1, 3'd3, 3'd4);
    send(2'd2, 3'd6, 3'd7);
    send(2'd3, 3'd7, 3'd1);
    send(2'd2, 3'd4, 3'd4);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("t2_full_ready", cmd_ready, 0);
      check("t2_stall_valid", rsp_valid, 1);
      check("t2_stall_data", rsp_data, alu_model(2'd0, 3'd1, 3'd2));
      check("t2_stall_busy", busy, 1);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    chk_spacing = 1'b1;
    prev_hs = -1;
    @(negedge clk);
    check("t2_full_pop_ready", cmd_ready, 0);
    @(posedge clk); #1;
    send(2'd1, 3'd2, 3'd0);
    wait_drain();
    chk_spacing = 1'b0;
    check("t2_issued", issued_cnt, 8'(hs_cnt));
    check("t2_hs_total", hs_cnt, 7);

    // 5: reset while driving with three commands queued
    rsp_ready = 1'b0;
    send(2'd0, 3'd2, 3'd3);
    send(2'd1, 3'd4, 3'd5);
    send(2'd2, 3'd2, 3'd6);
    send(2'd3, 3'd1, 3'd1);
    send(2'd0, 3'd7, 3'd7);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("t5_in_drive", alu_req, 1);
    check("t5_rst_cmd_ready", cmd_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    hs_cnt = 0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("t5_alu_req", alu_req, 0);
    check("t5_alu_fields", {alu_sel, alu_a, alu_b}, 0);
    check("t5_rsp", {rsp_valid, rsp_data, rsp_sel}, 0);
    check("t5_issued", issued_cnt, 0);
    check("t5_busy", busy, 0);
    check("t5_cmd_ready", cmd_ready, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t5_no_flushed_rsp", rsp_valid, 0);
    end
    @(posedge clk); #1;
    send(2'd2, 3'd6, 3'd6);
    wait_drain();
    check("t5_new_issued", issued_cnt, 1);

    // 4: streaming with push/pop overlap at count=1 and at full, issued_cnt wrap
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 300; i++) send(2'(i % 4), 3'(i % 8), 3'((i / 8) % 8));
    wait_drain();
    check("t4_issued_wrap", issued_cnt, 44);
    check("t4_hs_total", hs_cnt, 300);

    // 6: random valid gaps and random ready
    rnd_en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end
    rnd_en = 1'b0;
    @(posedge clk); #3;
    rsp_ready = 1'b1;
    wait_drain();
    check("t6_hs_total", hs_cnt, 1300);
    check("t6_issued", issued_cnt, 8'(hs_cnt));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
